robo_odometro: RTL and testbench

- Downstream stage of robo_1. Consumes its per-step commands (avancar, girar, remover) and keeps the robot's pose: row, column, orientation.
- Also keeps move and removal counters and raises sticky fault flags: out-of-map, conflicting command, trapped robot.
- Replaces hand-written pose tracking in simulation and gives the synthesizable top a pose/status source for display.

---
 rtl/robo_odometro.sv | 148 ++++++++++++++
 tb/tb_robo_odometro.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/robo_odometro.sv
// Pose and status tracker fed by the per-step commands of robo_1.
// Keeps row/column/orientation, move and removal counters, and sticky fault flags.
module robo_odometro #(
  parameter int          DIM     = 20,
  parameter int          LIN_INI = 1,
  parameter int          COL_INI = 1,
  parameter logic [1:0]  ORI_INI = 2'b00,
  parameter int          MAX_MOV = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       amostra,
  input  logic       avancar,
  input  logic       girar,
  input  logic       remover,
  output logic [4:0] linha,
  output logic [4:0] coluna,
  output logic [1:0] orientacao,
  output logic [7:0] qtd_movimentos,
  output logic [7:0] qtd_remocoes,
  output logic       anomalia,
  output logic       comando_invalido,
  output logic       preso,
  output logic       parado
);

  // state  | meaning
  // ATIVO  | strobes are decoded and applied
  // PARADO | halted by out-of-map advance or exhausted move budget; only reset leaves
  localparam logic ATIVO  = 1'b0;
  localparam logic PARADO = 1'b1;

  localparam logic [1:0] ORI_N = 2'b00;
  localparam logic [1:0] ORI_S = 2'b01;
  localparam logic [1:0] ORI_L = 2'b10;
  localparam logic [1:0] ORI_O = 2'b11;

  localparam logic [5:0] DIM_B     = 6'(DIM);
  localparam logic [7:0] MAX_MOV_B = 8'(MAX_MOV);

  logic       state, state_nxt;
  logic [2:0] giros, giros_nxt;
  logic [4:0] lin_nxt, col_nxt;
  logic [1:0] ori_nxt, ori_rot;
  logic [7:0] mov_nxt, rem_nxt, mov_inc;
  logic       anom_nxt, ci_nxt, preso_nxt;
  logic [5:0] tgt_lin, tgt_col;
  logic       fora;

  // Counter-clockwise rotation: N->O, O->S, S->L, L->N
  always_comb begin
    ori_rot = ORI_N;
    case (orientacao)
      ORI_N:   ori_rot = ORI_O;
      ORI_O:   ori_rot = ORI_S;
      ORI_S:   ori_rot = ORI_L;
      default: ori_rot = ORI_N;
    endcase
  end

  // Six-bit target so that 1-1 and DIM+1 are both representable as out-of-map
  always_comb begin
    tgt_lin = {1'b0, linha};
    tgt_col = {1'b0, coluna};
    case (orientacao)
      ORI_N:   tgt_lin = {1'b0, linha} - 6'd1;
      ORI_S:   tgt_lin = {1'b0, linha} + 6'd1;
      ORI_L:   tgt_col = {1'b0, coluna} + 6'd1;
      default: tgt_col = {1'b0, coluna} - 6'd1;
    endcase
    fora = (tgt_lin == 6'd0) || (tgt_lin > DIM_B) ||
           (tgt_col == 6'd0) || (tgt_col > DIM_B);
  end

  assign mov_inc = qtd_movimentos + 8'd1;

  always_comb begin
    state_nxt = state;
    giros_nxt = giros;
    lin_nxt   = linha;
    col_nxt   = coluna;
    ori_nxt   = orientacao;
    mov_nxt   = qtd_movimentos;
    rem_nxt   = qtd_remocoes;
    anom_nxt  = anomalia;
    ci_nxt    = comando_invalido;
    preso_nxt = preso;

    if (amostra && (state == ATIVO)) begin
      if (avancar) begin
        if (girar || remover) ci_nxt = 1'b1;
        if (fora) begin
          anom_nxt  = 1'b1;
          state_nxt = PARADO;
        end else begin
          lin_nxt   = tgt_lin[4:0];
          col_nxt   = tgt_col[4:0];
          mov_nxt   = mov_inc;
          giros_nxt = 3'd0;
          if (mov_inc == MAX_MOV_B) state_nxt = PARADO;
        end
      end else if (girar) begin
        if (remover) ci_nxt = 1'b1;
        ori_nxt = ori_rot;
        mov_nxt = mov_inc;
        // giros saturates at 4; the flag goes up on the step that reaches 4
        if (giros >= 3'd3) begin
          giros_nxt = 3'd4;
          preso_nxt = 1'b1;
        end else begin
          giros_nxt = giros + 3'd1;
        end
        if (mov_inc == MAX_MOV_B) state_nxt = PARADO;
      end else if (remover) begin
        if (qtd_remocoes != 8'hFF) rem_nxt = qtd_remocoes + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= ATIVO;
      giros            <= 3'd0;
      linha            <= 5'(LIN_INI);
      coluna           <= 5'(COL_INI);
      orientacao       <= ORI_INI;
      qtd_movimentos   <= 8'd0;
      qtd_remocoes     <= 8'd0;
      anomalia         <= 1'b0;
      comando_invalido <= 1'b0;
      preso            <= 1'b0;
    end else begin
      state            <= state_nxt;
      giros            <= giros_nxt;
      linha            <= lin_nxt;
      coluna           <= col_nxt;
      orientacao       <= ori_nxt;
      qtd_movimentos   <= mov_nxt;
      qtd_remocoes     <= rem_nxt;
      anomalia         <= anom_nxt;
      comando_invalido <= ci_nxt;
      preso            <= preso_nxt;
    end
  end

  assign parado = (state == PARADO);

endmodule

// File: tb/tb_robo_odometro.sv
// Directed bench for robo_odometro: five instances with different start poses / budgets
// share clock, reset and command lines; each has its own amostra strobe.
module tb_robo_odometro;

  logic       clock;
  logic       reset;
  logic [4:0] amostra;
  logic       avancar, girar, remover;

  logic [4:0] lin   [5];
  logic [4:0] col   [5];
  logic [1:0] ori   [5];
  logic [7:0] mov   [5];
  logic [7:0] rem   [5];
  logic       anom  [5];
  logic       ci    [5];
  logic       pres  [5];
  logic       par   [5];

  int n_cmp = 0;
  int n_err = 0;

  robo_odometro u0 (
    .clock(clock), .reset(reset), .amostra(amostra[0]),
    .avancar(avancar), .girar(girar), .remover(remover),
    .linha(lin[0]), .coluna(col[0]), .orientacao(ori[0]),
    .qtd_movimentos(mov[0]), .qtd_remocoes(rem[0]),
    .anomalia(anom[0]), .comando_invalido(ci[0]), .preso(pres[0]), .parado(par[0]));

  robo_odometro #(.LIN_INI(5), .COL_INI(5), .ORI_INI(2'b00)) u1 (
    .clock(clock), .reset(reset), .amostra(amostra[1]),
    .avancar(avancar), .girar(girar), .remover(remover),
    .linha(lin[1]), .coluna(col[1]), .orientacao(ori[1]),
    .qtd_movimentos(mov[1]), .qtd_remocoes(rem[1]),
    .anomalia(anom[1]), .comando_invalido(ci[1]), .preso(pres[1]), .parado(par[1]));

  robo_odometro #(.LIN_INI(1), .COL_INI(1), .ORI_INI(2'b10)) u2 (
    .clock(clock), .reset(reset), .amostra(amostra[2]),
    .avancar(avancar), .girar(girar), .remover(remover),
    .linha(lin[2]), .coluna(col[2]), .orientacao(ori[2]),
    .qtd_movimentos(mov[2]), .qtd_remocoes(rem[2]),
    .anomalia(anom[2]), .comando_invalido(ci[2]), .preso(pres[2]), .parado(par[2]));

  robo_odometro #(.LIN_INI(5), .COL_INI(5), .ORI_INI(2'b01)) u3 (
    .clock(clock), .reset(reset), .amostra(amostra[3]),
    .avancar(avancar), .girar(girar), .remover(remover),
    .linha(lin[3]), .coluna(col[3]), .orientacao(ori[3]),
    .qtd_movimentos(mov[3]), .qtd_remocoes(rem[3]),
    .anomalia(anom[3]), .comando_invalido(ci[3]), .preso(pres[3]), .parado(par[3]));

  robo_odometro #(.LIN_INI(5), .COL_INI(5), .ORI_INI(2'b00), .MAX_MOV(3)) u4 (
    .clock(clock), .reset(reset), .amostra(amostra[4]),
    .avancar(avancar), .girar(girar), .remover(remover),
    .linha(lin[4]), .coluna(col[4]), .orientacao(ori[4]),
    .qtd_movimentos(mov[4]), .qtd_remocoes(rem[4]),
    .anomalia(anom[4]), .comando_invalido(ci[4]), .preso(pres[4]), .parado(par[4]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One strobe on instance idx; returns at the following falling edge, after the update.
  task automatic strobe(input int idx, input logic av, input logic gi, input logic re);
    @(negedge clock);
    avancar = av; girar = gi; remover = re;
    amostra = '0;
    amostra[idx] = 1'b1;
    @(negedge clock);
    amostra = '0;
    avancar = 1'b0; girar = 1'b0; remover = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    amostra = '0;
    avancar = 1'b0; girar = 1'b0; remover = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Reset state
    chk("rst_lin0", lin[0], 1);
    chk("rst_col0", col[0], 1);
    chk("rst_ori0", ori[0], 0);
    chk("rst_mov0", mov[0], 0);
    chk("rst_rem0", rem[0], 0);
    chk("rst_flags0", {anom[0], ci[0], pres[0], par[0]}, 0);
    chk("rst_lin1", lin[1], 5);
    chk("rst_ori2", ori[2], 2);
    chk("rst_ori3", ori[3], 1);

    // Advance north out of row 1 halts the block
    strobe(0, 1'b1, 1'b0, 1'b0);
    chk("oob_anom", anom[0], 1);
    chk("oob_par", par[0], 1);
    chk("oob_lin", lin[0], 1);
    chk("oob_col", col[0], 1);
    chk("oob_mov", mov[0], 0);
    strobe(0, 1'b0, 1'b1, 1'b0);
    chk("halt_ori", ori[0], 0);
    chk("halt_mov", mov[0], 0);
    chk("halt_ci", ci[0], 0);

    // Four rotations from (5,5,N): O, S, L, N then trapped
    strobe(1, 1'b0, 1'b1, 1'b0);
    chk("rot1_ori", ori[1], 3);
    strobe(1, 1'b0, 1'b1, 1'b0);
    chk("rot2_ori", ori[1], 1);
    strobe(1, 1'b0, 1'b1, 1'b0);
    chk("rot3_ori", ori[1], 2);
    chk("rot3_preso", pres[1], 0);
    strobe(1, 1'b0, 1'b1, 1'b0);
    chk("rot4_ori", ori[1], 0);
    chk("rot4_mov", mov[1], 4);
    chk("rot4_preso", pres[1], 1);
    chk("rot4_par", par[1], 0);
    strobe(1, 1'b1, 1'b0, 1'b0);
    chk("rot_av_lin", lin[1], 4);
    chk("rot_av_preso", pres[1], 1);
    chk("rot_av_mov", mov[1], 5);

    // Strobe gating: avancar held with amostra low for 10 cycles
    @(negedge clock);
    avancar = 1'b1;
    repeat (10) @(negedge clock);
    avancar = 1'b0;
    chk("gate_lin", lin[1], 4);
    chk("gate_mov", mov[1], 5);

    // Walk east along row 1 to the map edge
    for (int i = 0; i < 19; i++) strobe(2, 1'b1, 1'b0, 1'b0);
    chk("east_col", col[2], 20);
    chk("east_mov", mov[2], 19);
    chk("east_anom", anom[2], 0);
    strobe(2, 1'b1, 1'b0, 1'b0);
    chk("edge_anom", anom[2], 1);
    chk("edge_par", par[2], 1);
    chk("edge_col", col[2], 20);
    chk("edge_mov", mov[2], 19);

    // Conflicting commands: advance wins and is still applied
    strobe(3, 1'b1, 1'b1, 1'b0);
    chk("conf_lin", lin[3], 6);
    chk("conf_ori", ori[3], 1);
    chk("conf_ci", ci[3], 1);
    chk("conf_mov", mov[3], 1);
    strobe(3, 1'b0, 1'b0, 1'b1);
    chk("rem_cnt", rem[3], 1);
    chk("rem_lin", lin[3], 6);
    chk("rem_col", col[3], 5);
    chk("rem_mov", mov[3], 1);
    strobe(3, 1'b0, 1'b1, 1'b1);
    chk("girrem_ori", ori[3], 2);
    chk("girrem_rem", rem[3], 1);
    chk("girrem_mov", mov[3], 2);

    // Move budget of 3
    strobe(4, 1'b0, 1'b1, 1'b0);
    strobe(4, 1'b0, 1'b1, 1'b0);
    chk("bud2_par", par[4], 0);
    strobe(4, 1'b0, 1'b1, 1'b0);
    chk("bud3_par", par[4], 1);
    chk("bud3_mov", mov[4], 3);
    chk("bud3_ori", ori[4], 2);
    strobe(4, 1'b0, 1'b1, 1'b0);
    chk("bud4_ori", ori[4], 2);
    chk("bud4_mov", mov[4], 3);

    // Asynchronous reset between clock edges
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_lin1", lin[1], 5);
    chk("arst_mov1", mov[1], 0);
    chk("arst_preso1", pres[1], 0);
    chk("arst_par4", par[4], 0);
    chk("arst_mov4", mov[4], 0);
    chk("arst_anom0", anom[0], 0);
    chk("arst_col2", col[2], 1);
    chk("arst_ci3", ci[3], 0);
    chk("arst_rem3", rem[3], 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
